// File: rtl/dmem_arbiter_if.sv
// Requester and dmem-side signal bundle for dmem_arbiter.
// The arbiter uses the slave modport; the requesters and dmem model use master.
interface dmem_arbiter_if;
  logic        req0;
  logic [31:0] addr0;
  logic        we0;
  logic [2:0]  memop0;
  logic [31:0] wdata0;
  logic        gnt0;
  logic        rvalid0;
  logic [31:0] rdata0;
  logic        err0;

  logic        req1;
  logic [31:0] addr1;
  logic        we1;
  logic [2:0]  memop1;
  logic [31:0] wdata1;
  logic        gnt1;
  logic        rvalid1;
  logic [31:0] rdata1;
  logic        err1;

  logic [31:0] mem_addr;
  logic        mem_we;
  logic [2:0]  mem_memop;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req0, addr0, we0, memop0, wdata0,
    input  req1, addr1, we1, memop1, wdata1,
    input  mem_rdata,
    output gnt0, rvalid0, rdata0, err0,
    output gnt1, rvalid1, rdata1, err1,
    output mem_addr, mem_we, mem_memop, mem_wdata
  );

  modport master (
    output req0, addr0, we0, memop0, wdata0,
    output req1, addr1, we1, memop1, wdata1,
    output mem_rdata,
    input  gnt0, rvalid0, rdata0, err0,
    input  gnt1, rvalid1, rdata1, err1,
    input  mem_addr, mem_we, mem_memop, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the synchronous-read data memory.
// Serialises accesses, holds address/memop through the read latency, rejects misaligned ops.
module dmem_arbiter #(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned PRIO_MODE  = 0,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rstn,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned    SW       = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [1:0]     WcntInit = 2'(RD_LAT - 1);
  localparam logic [SW-1:0]  ScntMax  = SW'(STARVE_MAX);

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  state_e        state_q;
  logic [1:0]    wcnt_q;
  logic [SW-1:0] scnt_q;
  logic          last_q;
  logic          owner_q;
  logic [31:0]   addr_q;
  logic [2:0]    memop_q;

  logic        tie_pick;
  logic        sel;
  logic        grant;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_memop;
  logic        sel_we;
  logic        misal;
  logic        rd_done;

  // b/bu never misalign; h/hu need even addresses; w and unused codes need word alignment.
  function automatic logic misaligned(input logic [31:0] a, input logic [2:0] op);
    logic r;
    case (op)
      3'b000, 3'b100: r = 1'b0;
      3'b001, 3'b101: r = a[0];
      default:        r = (a[1:0] != 2'b00);
    endcase
    return r;
  endfunction

  always_comb begin
    if (PRIO_MODE == 0) begin
      tie_pick = ~last_q;
    end else begin
      tie_pick = (scnt_q == ScntMax);
    end
    sel       = (bus.req0 && bus.req1) ? tie_pick : bus.req1;
    grant     = rstn && (state_q == StIdle) && (bus.req0 || bus.req1);
    sel_addr  = sel ? bus.addr1  : bus.addr0;
    sel_wdata = sel ? bus.wdata1 : bus.wdata0;
    sel_memop = sel ? bus.memop1 : bus.memop0;
    sel_we    = sel ? bus.we1    : bus.we0;
    misal     = misaligned(sel_addr, sel_memop);
    rd_done   = (state_q == StRdWait) && (wcnt_q == 2'd0);
  end

  always_comb begin
    bus.gnt0    = grant && !sel;
    bus.gnt1    = grant && sel;
    bus.err0    = grant && !sel && misal;
    bus.err1    = grant && sel && misal;
    // A misaligned load completes in its grant cycle with zero data.
    bus.rvalid0 = (rd_done && !owner_q) || (grant && !sel && misal && !sel_we);
    bus.rvalid1 = (rd_done && owner_q) || (grant && sel && misal && !sel_we);
    bus.rdata0  = (rd_done && !owner_q) ? bus.mem_rdata : 32'd0;
    bus.rdata1  = (rd_done && owner_q) ? bus.mem_rdata : 32'd0;

    bus.mem_addr  = 32'd0;
    bus.mem_memop = 3'd0;
    bus.mem_wdata = 32'd0;
    bus.mem_we    = 1'b0;
    if (grant) begin
      bus.mem_addr  = sel_addr;
      bus.mem_memop = sel_memop;
      bus.mem_wdata = sel_wdata;
      bus.mem_we    = sel_we && !misal;
    end else if (state_q == StRdWait) begin
      bus.mem_addr  = addr_q;
      bus.mem_memop = memop_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      wcnt_q  <= 2'd0;
      scnt_q  <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      addr_q  <= 32'd0;
      memop_q <= 3'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant && !sel_we && !misal) begin
            owner_q <= sel;
            addr_q  <= sel_addr;
            memop_q <= sel_memop;
            wcnt_q  <= WcntInit;
            state_q <= StRdWait;
          end
        end
        StRdWait: begin
          if (wcnt_q == 2'd0) begin
            state_q <= StIdle;
          end else begin
            wcnt_q <= wcnt_q - 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (grant) begin
        last_q <= sel;
      end

      if (!bus.req1 || (grant && sel)) begin
        scnt_q <= '0;
      end else if (grant && !sel && (scnt_q != ScntMax)) begin
        scnt_q <= scnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised scoreboard bench for dmem_arbiter: two configurations, a behavioural dmem,
// and a transaction-level reference model predicting grants and load responses.
module tb_dmem_arbiter;

  logic clk;
  logic rstn_a, rstn_b;
  logic sel;  // 0: check dut_a (RD_LAT 1, round-robin), 1: dut_b (RD_LAT 3, priority)

  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [2:0]  memop0, memop1;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  dmem_arbiter_if bus_a ();
  dmem_arbiter_if bus_b ();

  dmem_arbiter #(.RD_LAT(1), .PRIO_MODE(0), .STARVE_MAX(4)) dut_a (
    .clk (clk),
    .rstn(rstn_a),
    .bus (bus_a)
  );

  dmem_arbiter #(.RD_LAT(3), .PRIO_MODE(1), .STARVE_MAX(4)) dut_b (
    .clk (clk),
    .rstn(rstn_b),
    .bus (bus_b)
  );

  assign bus_a.req0 = req0;     assign bus_b.req0 = req0;
  assign bus_a.addr0 = addr0;   assign bus_b.addr0 = addr0;
  assign bus_a.we0 = we0;       assign bus_b.we0 = we0;
  assign bus_a.memop0 = memop0; assign bus_b.memop0 = memop0;
  assign bus_a.wdata0 = wdata0; assign bus_b.wdata0 = wdata0;
  assign bus_a.req1 = req1;     assign bus_b.req1 = req1;
  assign bus_a.addr1 = addr1;   assign bus_b.addr1 = addr1;
  assign bus_a.we1 = we1;       assign bus_b.we1 = we1;
  assign bus_a.memop1 = memop1; assign bus_b.memop1 = memop1;
  assign bus_a.wdata1 = wdata1; assign bus_b.wdata1 = wdata1;
  assign bus_a.mem_rdata = mem_rdata;
  assign bus_b.mem_rdata = mem_rdata;

  logic        v_rstn, v_gnt0, v_gnt1, v_rvalid0, v_rvalid1, v_err0, v_err1, v_mem_we;
  logic [31:0] v_rdata0, v_rdata1, v_mem_addr, v_mem_wdata;
  logic [2:0]  v_mem_memop;
  int          cfg_lat, cfg_prio;

  assign v_rstn      = sel ? rstn_b : rstn_a;
  assign v_gnt0      = sel ? bus_b.gnt0 : bus_a.gnt0;
  assign v_gnt1      = sel ? bus_b.gnt1 : bus_a.gnt1;
  assign v_rvalid0   = sel ? bus_b.rvalid0 : bus_a.rvalid0;
  assign v_rvalid1   = sel ? bus_b.rvalid1 : bus_a.rvalid1;
  assign v_err0      = sel ? bus_b.err0 : bus_a.err0;
  assign v_err1      = sel ? bus_b.err1 : bus_a.err1;
  assign v_rdata0    = sel ? bus_b.rdata0 : bus_a.rdata0;
  assign v_rdata1    = sel ? bus_b.rdata1 : bus_a.rdata1;
  assign v_mem_we    = sel ? bus_b.mem_we : bus_a.mem_we;
  assign v_mem_addr  = sel ? bus_b.mem_addr : bus_a.mem_addr;
  assign v_mem_wdata = sel ? bus_b.mem_wdata : bus_a.mem_wdata;
  assign v_mem_memop = sel ? bus_b.mem_memop : bus_a.mem_memop;
  assign cfg_lat     = sel ? 3 : 1;
  assign cfg_prio    = sel ? 1 : 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural dmem: word array, lane-merged writes, RD_LAT-deep registered read.
  logic [31:0] tmem [256];
  logic [31:0] pipe [3];

  function automatic logic [31:0] dmem_read(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] sh;
    sh = tmem[a[9:2]] >> {a[1:0], 3'b000};
    case (op)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return tmem[a[9:2]];
    endcase
  endfunction

  function automatic logic [31:0] dmem_merge(input logic [31:0] a, input logic [2:0] op,
                                             input logic [31:0] d);
    logic [31:0] w;
    w = tmem[a[9:2]];
    case (op)
      3'd0:    w[a[1:0]*8 +: 8] = d[7:0];
      3'd1:    w[a[1]*16 +: 16] = d[15:0];
      3'd2:    w = d;
      default: ;
    endcase
    return w;
  endfunction

  always @(posedge clk) begin
    if (v_mem_we) tmem[v_mem_addr[9:2]] <= dmem_merge(v_mem_addr, v_mem_memop, v_mem_wdata);
    pipe[0] <= dmem_read(v_mem_addr, v_mem_memop);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign mem_rdata = pipe[cfg_lat-1];

  // Reference model: byte-addressed memory and access-level rules.
  logic [7:0] refmem [1024];

  function automatic int op_size(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd4) return 1;
    if (op == 3'd1 || op == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit ref_misaligned(input logic [31:0] a, input logic [2:0] op);
    return (a % op_size(op)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] v = 0;
    int base = int'(a & 32'h3ff);
    for (int i = 0; i < op_size(op); i++) v |= 32'(refmem[base+i]) << (8 * i);
    if (op == 3'd0 && v[7])  v |= 32'hffffff00;
    if (op == 3'd1 && v[15]) v |= 32'hffff0000;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
    int base = int'(a & 32'h3ff);
    if (op > 3'd2) return;  // only b/h/w write; other codes are no-write
    for (int i = 0; i < op_size(op); i++) refmem[base+i] = d[8*i +: 8];
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  int          m_busy = 0;
  int          m_scnt = 0;
  int          m_last = 1;
  logic [31:0] m_addr;
  logic [2:0]  m_op;
  bit          gseen0, gseen1;

  always @(negedge clk) begin
    int          w;
    logic [31:0] a, d;
    logic [2:0]  op;
    bit          we, mis;
    gseen0 = 0;
    gseen1 = 0;
    if (!v_rstn) begin
      m_busy = 0; m_scnt = 0; m_last = 1;
      exp_q.delete();
      chk("reset_flags", {v_gnt0, v_gnt1, v_rvalid0, v_rvalid1, v_err0, v_err1, v_mem_we,
                          v_mem_memop}, 0);
      chk("reset_bus", {v_mem_addr, v_mem_wdata}, 0);
      chk("reset_rdata", {v_rdata0, v_rdata1}, 0);
    end else begin
      w = -1;
      if (m_busy > 0) begin
        chk("rdwait_hold", {v_mem_we, v_mem_addr, v_mem_memop}, {1'b0, m_addr, m_op});
        m_busy--;
      end else if (req0 && req1) begin
        if (cfg_prio == 1) w = (m_scnt == 4) ? 1 : 0;
        else               w = (m_last == 1) ? 0 : 1;
      end else if (req0) w = 0;
      else if (req1)     w = 1;

      chk("gnt", {v_gnt0, v_gnt1}, {w == 0, w == 1});
      mis = 0;
      if (w >= 0) begin
        a  = (w == 0) ? addr0 : addr1;
        d  = (w == 0) ? wdata0 : wdata1;
        op = (w == 0) ? memop0 : memop1;
        we = (w == 0) ? we0 : we1;
        mis = ref_misaligned(a, op);
        chk("grant_bus", {v_mem_we, v_mem_addr, v_mem_memop}, {we && !mis, a, op});
        if (we && !mis) begin
          chk("mem_wdata", v_mem_wdata, d);
          ref_store(a, op, d);
        end
        if (!we) begin
          if (mis) exp_q.push_back('{port: w, data: 32'd0, due: cyc});
          else begin
            exp_q.push_back('{port: w, data: ref_load(a, op), due: cyc + cfg_lat});
            m_busy = cfg_lat; m_addr = a; m_op = op;
          end
        end
        m_last = w;
        if (w == 1) m_scnt = 0;
        else if (req1) m_scnt++;
        gseen0 = (w == 0);
        gseen1 = (w == 1);
      end
      if (!req1) m_scnt = 0;
      chk("err", {v_err0, v_err1}, {w == 0 && mis, w == 1 && mis});
    end
  end

  logic [31:0] last_rdata;
  int          last_rport;

  // Response monitor: pops the scoreboard whenever a load response is presented.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (v_rvalid0 || v_rvalid1) begin
      chk("one_rvalid", {v_rvalid0, v_rvalid1} == 2'b11, 0);
      last_rport = v_rvalid1 ? 1 : 0;
      last_rdata = v_rvalid1 ? v_rdata1 : v_rdata0;
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rvalid_port", last_rport, e.port);
        chk("rvalid_cycle", cyc, e.due);
        chk("rdata", last_rdata, e.data);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      chk("rvalid_missing", 0, 1);
    end
  end

  task automatic set_port(input int p, input bit we, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = 1; we0 = we; memop0 = op; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = we; memop1 = op; addr1 = a; wdata1 = d; end
  endtask

  task automatic access(input int p, input bit we, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, output int waited);
    @(posedge clk); #1;
    set_port(p, we, op, a, d);
    waited = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if ((p == 0) ? gseen0 : gseen1) begin waited = i; break; end
    end
    #1;
    if (p == 0) req0 = 0; else req1 = 0;
    if (waited < 0) chk("access_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk); #2;
      if (exp_q.size() == 0 && m_busy == 0) break;
    end
    if (i == 50) chk("idle_timeout", 1, 0);
  endtask

  task automatic hold_both(input int n, output logic [19:0] seq);
    seq = '1;
    @(posedge clk); #1;
    set_port(0, 1, 3'd2, 32'h130, $urandom);
    set_port(1, 1, 3'd2, 32'h134, $urandom);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      seq[2*i +: 2] = gseen1 ? 2'd1 : (gseen0 ? 2'd0 : 2'd3);
    end
    #1; req0 = 0; req1 = 0;
  endtask

  task automatic run_random(input int n);
    logic [2:0] ops [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (req0 && !gseen0) begin
        if ($urandom_range(0, 15) == 0) req0 = 0;
      end else begin
        req0 = ($urandom_range(0, 2) != 0);
        set_port(0, 1'($urandom_range(0, 1)), ops[$urandom_range(0, 7)],
                 32'h100 + $urandom_range(0, 63), $urandom);
        req0 = req0 && ($urandom_range(0, 2) != 0);
      end
      if (req1 && !gseen1) begin
        if ($urandom_range(0, 15) == 0) req1 = 0;
      end else begin
        set_port(1, 1'($urandom_range(0, 1)), ops[$urandom_range(0, 7)],
                 32'h100 + $urandom_range(0, 63), $urandom);
        req1 = ($urandom_range(0, 2) != 0);
      end
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          wc;
    logic [19:0] seq;
    for (int i = 0; i < 256; i++) tmem[i] = 0;
    for (int i = 0; i < 1024; i++) refmem[i] = 0;
    for (int i = 0; i < 3; i++) pipe[i] = 0;
    req0 = 0; we0 = 0; addr0 = 0; memop0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; memop1 = 0; wdata1 = 0;
    sel = 0; rstn_a = 0; rstn_b = 0;
    repeat (3) @(posedge clk);
    #1 rstn_a = 1;

    hold_both(6, seq);
    chk("rr_sequence", seq[11:0], 12'h444);

    access(0, 1, 3'd2, 32'h100, 32'hdeadbeef, wc);
    chk("store_wait", wc, 0);
    access(0, 0, 3'd2, 32'h100, 32'd0, wc);
    wait_idle();
    chk("lw_0x100", last_rdata, 32'hdeadbeef);

    access(0, 1, 3'd0, 32'h203, 32'h000000aa, wc);
    access(0, 0, 3'd4, 32'h203, 32'd0, wc);
    wait_idle();
    chk("lbu_0x203", last_rdata, 32'h000000aa);
    access(0, 0, 3'd0, 32'h203, 32'd0, wc);
    wait_idle();
    chk("lb_0x203", last_rdata, 32'hffffffaa);

    access(1, 0, 3'd2, 32'h102, 32'd0, wc);
    wait_idle();
    chk("mis_lw_port", last_rport, 1);
    chk("mis_lw_data", last_rdata, 0);
    access(1, 1, 3'd2, 32'h102, 32'h12345678, wc);
    access(0, 0, 3'd2, 32'h100, 32'd0, wc);
    wait_idle();
    chk("mis_sw_nowrite", last_rdata, 32'hdeadbeef);

    run_random(400);
    wait_idle();

    @(posedge clk); #1;
    rstn_a = 0;
    sel = 1;
    repeat (2) @(posedge clk);
    #1 rstn_b = 1;

    hold_both(10, seq);
    chk("prio_sequence", seq, 20'h40100);

    access(1, 0, 3'd4, 32'h203, 32'd0, wc);
    wait_idle();
    chk("lat3_lbu", last_rdata, 32'h000000aa);

    run_random(400);
    wait_idle();

    access(0, 0, 3'd2, 32'h100, 32'd0, wc);
    #3 rstn_b = 0;
    #1;
    chk("midread_reset_outs", {bus_b.gnt0, bus_b.gnt1, bus_b.rvalid0, bus_b.rvalid1,
                               bus_b.err0, bus_b.err1, bus_b.mem_we, bus_b.mem_addr}, 0);
    repeat (3) @(posedge clk);
    #1 rstn_b = 1;
    access(1, 1, 3'd2, 32'h120, 32'h0badf00d, wc);
    chk("post_reset_grant", wc, 0);
    access(1, 0, 3'd2, 32'h120, 32'd0, wc);
    wait_idle();
    chk("post_reset_load", last_rdata, 32'h0badf00d);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the data memory `dmem`. It shares the single `dmem` port between the CPU load/store unit (port 0) and a secondary master such as a debug loader or DMA engine (port 1). It serialises their accesses, holds address and memop stable for the full synchronous-read latency, and rejects misaligned accesses before they reach memory. It sits between the requesters and `dmem`. `clk` drives `dmem` rdclk/wrclk at the top level.

## Interface
Parameters:
- `RD_LAT`, default 1: cycles from grant to read data valid at `mem_rdata`. Legal range 1..3.
- `PRIO_MODE`, default 0: 0 = round-robin; 1 = port 0 fixed priority with starvation guard.
- `STARVE_MAX`, default 4: in `PRIO_MODE`=1, the number of consecutive port-0 grants while port 1 waits, after which port 1 is forced.

Ports (x = 0, 1):
- `clk` input 1: the single clock, rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `reqx` input 1: access request; held with its fields until `gntx`.
- `addrx` input 32: byte address.
- `wex` input 1: 1 = store, 0 = load.
- `memopx` input 3: `dmem` encoding (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `wdatax` input 32: store data.
- `gntx` output 1: request accepted this cycle.
- `rvalidx` output 1: load data (or load error) valid this cycle.
- `rdatax` output 32: load data, meaningful only while `rvalidx`.
- `errx` output 1: one-cycle pulse on a misaligned access.
- `mem_addr` output 32: address to `dmem`.
- `mem_we` output 1: write enable to `dmem`.
- `mem_memop` output 3: memop to `dmem`.
- `mem_wdata` output 32: store data to `dmem`.
- `mem_rdata` input 32: `dmem` dataout.

## Operation
- Two states, IDLE and RD_WAIT, plus a wait counter `wcnt` (2 bits).
- IDLE:
  - Select a winner among the asserted `reqx` (see arbitration below).
  - Assert the winner's `gntx` combinationally in the same cycle.
  - Drive the winner's addr, memop and wdata onto `mem_*`.
- Aligned store: `mem_we`=1 for the grant cycle only, and the state stays IDLE. Back-to-back stores are possible every cycle.
- Aligned load:
  - `mem_we`=0. Latch the owner, addr and memop into registers, then go to RD_WAIT with `wcnt`=RD_LAT-1.
  - In RD_WAIT, `mem_addr` and `mem_memop` come from the latched registers, so `dmem` byte/half lane select stays stable. `mem_we`=0.
  - `wcnt` decrements each cycle. When `wcnt`=0: `rvalid`(owner)=1, `rdata`(owner)=`mem_rdata`, and the next state is IDLE.
- Misaligned access: w with `addr[1:0]`≠00, or h/hu with `addr[0]`=1.
  - `gntx`=1, `errx`=1 in the grant cycle; `mem_we` is forced 0 and no RD_WAIT is entered.
  - For a load, `rvalidx`=1 in the same cycle with `rdatax`=0.
- Arbitration, `PRIO_MODE`=0: round-robin pointer `last`, reset value 1 (so port 0 wins the first tie). On a tie, the port ≠ `last` wins. `last` updates on every grant.
- Arbitration, `PRIO_MODE`=1:
  - Port 0 wins ties.
  - Counter `scnt` increments on each port-0 grant made while `req1`=1. It clears on any port-1 grant or when `req1`=0.
  - When `scnt`=STARVE_MAX, port 1 wins the next tie.
- No grant is issued in RD_WAIT. Requests arriving in RD_WAIT wait and are arbitrated in the IDLE cycle after `rvalid`.
- Unused memop codes (011, 110, 111) pass through unchanged; `dmem` treats them as w-load / no-write. They count as aligned when `addr[1:0]`=00.

## Timing
- Reset (async assert, sync-to-clk deassert at the bench):
  - state IDLE, `wcnt`=0, `scnt`=0, `last`=1.
  - All `gntx`, `rvalidx`, `errx`, `mem_we` = 0; `mem_addr`, `mem_memop`, `mem_wdata`, `rdatax` = 0.
  - `gntx` is gated by `rstn`.
- Store latency: 0 cycles; memory is written at the rising edge ending the grant cycle.
- Load latency: `rvalid` at grant cycle + RD_LAT. Throughput is one load per RD_LAT+1 cycles.
- Reset asserted in RD_WAIT: the access is abandoned, no `rvalid` is issued, and the block returns to IDLE.
- `req` deasserted before grant: legal, the request is withdrawn. Deasserting `req` after grant has no effect.
- At most one `gntx` and one `rvalidx` high in any cycle.

## Test plan
- Store then load, port 0: sw 0xDEADBEEF @0x100, then lw @0x100 → `gnt0` same cycle each; `rvalid0`=1 exactly RD_LAT cycles after the load grant; `rdata0`=0xDEADBEEF.
- Byte lanes: sb 0xAA @0x203, lbu @0x203 → 0x000000AA; lb @0x203 → 0xFFFFFFAA. `mem_addr` stays 0x203 throughout RD_WAIT.
- Round-robin: both ports hold store requests for 6 cycles → grants alternate 0,1,0,1,0,1, port 0 first after reset.
- `PRIO_MODE`=1, `STARVE_MAX`=4: both ports request continuously → 4 port-0 grants then 1 port-1 grant, repeating.
- Misaligned: lw @0x102 on port 1 → `gnt1`, `err1`, `rvalid1` in the same cycle; `rdata1`=0; `mem_we`=0; memory unchanged on readback.
- Reset mid-read: `rstn` low during RD_WAIT with `RD_LAT`=3 → no `rvalid`; all outputs 0; the first request after reset is granted in IDLE.
